fft16_sdf_ctrl: RTL

- Sequencer for the 16-point radix-2 DIF single-delay-feedback (SDF) FFT pipeline: four stages with delay lines of 8, 4, 2 and 1, fed by the twiddle ROM.
- Accepts samples with a valid/ready handshake and generates the pipeline advance enable, per-stage butterfly selects and twiddle exponents.
- Tags valid samples through the pipeline latency, flushes the last frame and reports output order (bit-reversed index) and frame completion.
- Sits between the sample source and the FFT datapath/ROM.

---
 rtl/fft16_sdf_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fft16_sdf_ctrl.sv
// fft16_sdf_ctrl: sequencer for an N-point radix-2 DIF single-delay-feedback FFT.
// Accepts samples (valid/ready) and drives the datapath advance enable, the
// per-stage butterfly selects and twiddle exponents. It also tags valid samples
// through the N-1 advance latency, flushes the last frame, and reports output
// bin order and frame completion.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in_valid      sample present at the input
//   in_ready      sample accepted this cycle when in_valid is high (low only in FLUSH)
//   adv           datapath advance: all delay lines shift
//   bf_sel        butterfly select, bit s = stage s
//   tw_addr       twiddle exponent of W_N, field s = [s*(LOG2N-1) +: LOG2N-1]
//   out_valid     datapath output is a valid bin this cycle
//   out_idx       natural bin index of that output (0 when out_valid is low)
//   frame_done    pulses with the last bin of a frame
//   busy, state   controller state (0 IDLE, 1 RUN, 2 HOLD, 3 FLUSH)
//   stall_cnt     saturating count of HOLD cycles       (FFT16_CTRL_STATUS_EN)
//   frame_cnt     wrapping count of completed frames    (FFT16_CTRL_STATUS_EN)
//
// Optional feature macro: FFT16_CTRL_STATUS_EN. When it is undefined, both
// status counters read 0 and no counter flops are built.
//
// Output decodes are combinational from the registered advance counter, tag
// register and state. They are valid in the cycle that adv is high.

module fft16_sdf_ctrl #(
  parameter  int unsigned N      = 16,
  parameter  int unsigned STAT_W = 16,
  localparam int unsigned LOG2N  = $clog2(N),
  localparam int unsigned LAT    = N - 1,
  localparam int unsigned TW_W   = LOG2N - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    adv,
  output logic [LOG2N-1:0]        bf_sel,
  output logic [LOG2N*TW_W-1:0]   tw_addr,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    frame_done,
  output logic                    busy,
  output logic [1:0]              state,
  output logic [STAT_W-1:0]       stall_cnt,
  output logic [STAT_W-1:0]       frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LOG2N-1:0] t_q;
  logic [LAT-1:0]   tag_q;
  logic             accept_c;
  logic [LOG2N-1:0] oidx_nat_c;

  // Handshake and advance enable
  assign in_ready = (state_q != FLUSH);
  assign accept_c = in_valid & in_ready;
  assign adv      = accept_c | (state_q == FLUSH);
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

  // Advance counter, valid-tag shift register and state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (adv) begin
        t_q   <= t_q + LOG2N'(1);
        tag_q <= {tag_q[LAT-2:0], accept_c};
      end
    end
  end

  // Next-state logic. A stall at t==0 is a frame boundary, so it flushes
  // rather than holding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (!in_valid) begin
          if (t_q != '0)        state_d = HOLD;
          else if (tag_q != '0) state_d = FLUSH;
          else                  state_d = IDLE;
        end
      end
      HOLD: begin
        if (in_valid) state_d = RUN;
      end
      FLUSH: begin
        if (t_q == LOG2N'(N - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-stage decode. Stage s lags stage s-1 by that stage's delay (N>>s).
  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int unsigned OFF     = (s == 0) ? 0 : (N - (N >> s));
    localparam int unsigned TW_MASK = (N >> (s + 1)) - 1;
    logic [LOG2N-1:0] c;

    assign c         = t_q - LOG2N'(OFF);
    assign bf_sel[s] = c[LOG2N-1-s];
    assign tw_addr[s*TW_W +: TW_W] =
      bf_sel[s] ? '0 : TW_W'((c & LOG2N'(TW_MASK)) << s);
  end

  // Output tagging. The bin order is the bit reversal of the output count.
  assign oidx_nat_c = t_q - LOG2N'(LAT);
  assign out_valid  = adv & tag_q[LAT-1];
  assign frame_done = out_valid & (oidx_nat_c == LOG2N'(N - 1));

  always_comb begin
    out_idx = '0;
    if (out_valid) begin
      for (int i = 0; i < LOG2N; i++) out_idx[i] = oidx_nat_c[LOG2N-1-i];
    end
  end

`ifdef FFT16_CTRL_STATUS_EN
  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] frame_q;

  // Status counters: saturating stall cycles, wrapping frame count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      frame_q <= '0;
    end else begin
      if ((state_q == HOLD) && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
      if (frame_done)                           frame_q <= frame_q + STAT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign frame_cnt = frame_q;
`else
  assign stall_cnt = '0;
  assign frame_cnt = '0;
`endif

endmodule
